memory_arbiter: RTL and testbench

Shares the single external memory port between the fetch stage (instruction reads) and the memory stage (data reads/writes). Data requests have fixed priority, with a starvation guard that forces a fetch grant after a bounded run of data grants. One transaction is outstanding at a time. Fetch requests abandoned mid-flight (flush) are completed on the bus and their data discarded.

---
 rtl/memory_arbiter_if.sv | 37 +++
 rtl/memory_arbiter.sv | 83 ++++++++
 tb/tb_memory_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: request, response and memory-bus signals of the memory arbiter
//   slave  : arbiter side (takes fetch/data requests and bus responses, drives results and bus commands)
//   master : environment side (requesters plus external memory)
interface memory_arbiter_if;
  logic        fetch_enable;
  logic [31:0] fetch_address;
  logic [31:0] fetch_data;
  logic        fetch_valid;
  logic        data_read;
  logic        data_write;
  logic [31:0] data_address;
  logic [31:0] data_write_data;
  logic [3:0]  data_byte_enable;
  logic [31:0] data_read_data;
  logic        data_valid;
  logic        data_wait;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_wait;
  logic        mem_read_valid;
  logic [31:0] mem_read_data;
  modport slave (
    input  fetch_enable, fetch_address, data_read, data_write, data_address, data_write_data,
           data_byte_enable, mem_wait, mem_read_valid, mem_read_data,
    output fetch_data, fetch_valid, data_read_data, data_valid, data_wait,
           mem_address, mem_read, mem_write, mem_write_data, mem_byte_enable
  );
  modport master (
    output fetch_enable, fetch_address, data_read, data_write, data_address, data_write_data,
           data_byte_enable, mem_wait, mem_read_valid, mem_read_data,
    input  fetch_data, fetch_valid, data_read_data, data_valid, data_wait,
           mem_address, mem_read, mem_write, mem_write_data, mem_byte_enable
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one external memory port between instruction fetch and data accesses
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   bus.fetch_*    : fetch read request, registered instruction word and valid pulse
//   bus.data_*     : load/store request, registered load data, valid pulse, stall
//   bus.mem_*      : single-outstanding memory command and read response
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input logic clock,
  input logic reset_n,
  memory_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, FETCH_CMD, FETCH_RESP, DATA_READ_CMD, DATA_READ_RESP, DATA_WRITE_CMD} state_t;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  state_t state, state_next;
  logic [CW-1:0] count, count_next;
  logic [31:0] addr_q, wdata_q;
  logic [3:0] be_q;
  logic fetch_elig, data_elig, grant_data, grant_fetch, fetch_hit;
  // a requester whose result is being presented this cycle may not be re-granted yet
  assign fetch_elig = bus.fetch_enable && !bus.fetch_valid;
  assign data_elig = (bus.data_read || bus.data_write) && !bus.data_valid;
  // a fetch whose address moved on (flush) still drains the bus but its data is discarded
  assign fetch_hit = bus.fetch_enable && bus.fetch_address == addr_q;
  always_comb begin
    state_next = state;
    count_next = count;
    grant_data = 1'b0;
    grant_fetch = 1'b0;
    case (state)
      IDLE: begin
        grant_data = data_elig && (!bus.fetch_enable || count < LIMIT);
        grant_fetch = !grant_data && fetch_elig;
        if (grant_data) begin
          state_next = bus.data_write ? DATA_WRITE_CMD : DATA_READ_CMD;
          count_next = !bus.fetch_enable ? '0 : count == LIMIT ? count : count + 1'b1;
        end else if (grant_fetch) begin
          state_next = FETCH_CMD;
          count_next = '0;
        end
      end
      FETCH_CMD:      state_next = bus.mem_wait ? FETCH_CMD : FETCH_RESP;
      DATA_READ_CMD:  state_next = bus.mem_wait ? DATA_READ_CMD : DATA_READ_RESP;
      DATA_WRITE_CMD: state_next = bus.mem_wait ? DATA_WRITE_CMD : IDLE;
      FETCH_RESP:     state_next = bus.mem_read_valid ? IDLE : FETCH_RESP;
      DATA_READ_RESP: state_next = bus.mem_read_valid ? IDLE : DATA_READ_RESP;
      default:        state_next = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      bus.fetch_data <= '0;
      bus.fetch_valid <= 1'b0;
      bus.data_read_data <= '0;
      bus.data_valid <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      bus.fetch_valid <= state == FETCH_RESP && bus.mem_read_valid && fetch_hit;
      bus.data_valid <= (state == DATA_READ_RESP && bus.mem_read_valid) || (state == DATA_WRITE_CMD && !bus.mem_wait);
      if (state == FETCH_RESP && bus.mem_read_valid && fetch_hit) bus.fetch_data <= bus.mem_read_data;
      if (state == DATA_READ_RESP && bus.mem_read_valid) bus.data_read_data <= bus.mem_read_data;
      if (grant_data || grant_fetch) begin
        addr_q <= grant_data ? bus.data_address : bus.fetch_address;
        wdata_q <= grant_data && bus.data_write ? bus.data_write_data : '0;
        be_q <= grant_data && bus.data_write ? bus.data_byte_enable : 4'hf;
      end
    end
  end
  // commands decode straight from the state register, so they are glitch-free and hold while mem_wait
  assign bus.mem_read = state == FETCH_CMD || state == DATA_READ_CMD;
  assign bus.mem_write = state == DATA_WRITE_CMD;
  assign bus.mem_address = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_byte_enable = be_q;
  assign bus.data_wait = reset_n && (bus.data_read || bus.data_write) && !bus.data_valid;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed vectors, corner sequences and a randomized run against a transaction model
module tb_memory_arbiter;
  localparam int LIMIT = 4;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  memory_arbiter_if bus();
  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;
  int total = 0;
  int bad = 0;
  typedef struct {
    int fe, fa, dr, dw, da, dwd, be, mw, mrv, mrd;
    int mr, mwr, addr, wd, ebe, fv, fd, dv, dd, dwt;
  } vec_t;
  vec_t vecs[$];
  int owner;
  bit wr, acc, e_fv, e_dv;
  int cnt;
  logic [31:0] m_addr, m_wd, e_fd, e_dd;
  logic [3:0] m_be;
  function automatic logic [159:0] tup(input logic mr, input logic mw, input logic [31:0] a, input logic [31:0] wd,
                                       input logic [3:0] be, input logic fv, input logic [31:0] fd, input logic dv,
                                       input logic [31:0] dd, input logic dwt, input bit masked);
    logic cmd;
    cmd = !masked || mr || mw;
    return {23'd0, mr, mw, cmd ? a : 32'd0, cmd ? wd : 32'd0, cmd ? be : 4'd0,
            fv, (!masked || fv) ? fd : 32'd0, dv, (!masked || dv) ? dd : 32'd0, dwt};
  endfunction
  function automatic logic [159:0] dut_tup(input bit masked);
    return tup(bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_write_data, bus.mem_byte_enable,
               bus.fetch_valid, bus.fetch_data, bus.data_valid, bus.data_read_data, bus.data_wait, masked);
  endfunction
  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic fe, input logic [31:0] fa, input logic dr, input logic dw, input logic [31:0] da,
                       input logic [31:0] dwd, input logic [3:0] be, input logic mw, input logic mrv, input logic [31:0] mrd);
    bus.fetch_enable = fe;
    bus.fetch_address = fa;
    bus.data_read = dr;
    bus.data_write = dw;
    bus.data_address = da;
    bus.data_write_data = dwd;
    bus.data_byte_enable = be;
    bus.mem_wait = mw;
    bus.mem_read_valid = mrv;
    bus.mem_read_data = mrd;
  endtask
  // transaction-level reference: one owner at a time, command phase then response phase
  task automatic model_step();
    bit n_fv, n_dv, fe;
    n_fv = 1'b0;
    n_dv = 1'b0;
    fe = bus.fetch_enable;
    if (owner == 0) begin
      if ((bus.data_read || bus.data_write) && !e_dv && (!fe || cnt < LIMIT)) begin
        owner = 2;
        wr = bus.data_write;
        acc = 1'b0;
        m_addr = bus.data_address;
        m_wd = wr ? bus.data_write_data : 32'd0;
        m_be = wr ? bus.data_byte_enable : 4'hf;
        cnt = fe ? (cnt < LIMIT ? cnt + 1 : cnt) : 0;
      end else if (fe && !e_fv) begin
        owner = 1;
        wr = 1'b0;
        acc = 1'b0;
        m_addr = bus.fetch_address;
        m_wd = 32'd0;
        m_be = 4'hf;
        cnt = 0;
      end
    end else if (!acc) begin
      if (!bus.mem_wait) begin
        if (wr) begin
          owner = 0;
          n_dv = 1'b1;
        end else acc = 1'b1;
      end
    end else if (bus.mem_read_valid) begin
      if (owner == 1) begin
        if (fe && bus.fetch_address == m_addr) begin
          n_fv = 1'b1;
          e_fd = bus.mem_read_data;
        end
      end else begin
        n_dv = 1'b1;
        e_dd = bus.mem_read_data;
      end
      owner = 0;
    end
    e_fv = n_fv;
    e_dv = n_dv;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    string exp_s;
    byte grants[10];
    int ng;
    bit prev;
    logic [31:0] fa_r, da_r;
    int k;
    vecs.push_back('{1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 'h100, 0, 'hf, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 'h100, 0, 0, 0, 0, 0, 0, 1, 'h13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 'h100, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 'h13, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 1, 'h200, 32'hDEADBEEF, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    for (int i = 0; i < 3; i++)
      vecs.push_back('{0, 0, 0, 1, 'h200, 32'hDEADBEEF, 3, 1, 0, 0, 0, 1, 'h200, 32'hDEADBEEF, 3, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 1, 'h200, 32'hDEADBEEF, 3, 0, 0, 0, 0, 1, 'h200, 32'hDEADBEEF, 3, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 0, 0, 1, 'h200, 32'hDEADBEEF, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 'h104, 1, 0, 'h400, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 'h104, 1, 0, 'h400, 0, 0, 0, 0, 0, 1, 0, 'h400, 0, 'hf, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 'h104, 1, 0, 'h400, 0, 0, 0, 1, 32'hCAFE0001, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 'h104, 1, 0, 'h400, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hCAFE0001, 0});
    vecs.push_back('{1, 'h104, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 'h104, 0, 'hf, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 'h104, 0, 0, 0, 0, 0, 0, 1, 'h93, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 'h104, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 'h93, 0, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clock);
    #1 check("reset", dut_tup(0), 160'd0);
    reset_n = 1'b1;
    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].fe != 0, vecs[i].fa, vecs[i].dr != 0, vecs[i].dw != 0, vecs[i].da, vecs[i].dwd,
            vecs[i].be[3:0], vecs[i].mw != 0, vecs[i].mrv != 0, vecs[i].mrd);
      #1 check($sformatf("vec%0d", i), dut_tup(1),
               tup(vecs[i].mr != 0, vecs[i].mwr != 0, vecs[i].addr, vecs[i].wd, vecs[i].ebe[3:0], vecs[i].fv != 0,
                   vecs[i].fd, vecs[i].dv != 0, vecs[i].dd, vecs[i].dwt != 0, 1));
    end
    // starvation: fetch steps aside only in the cycles a load completes, so data keeps winning until the guard trips
    exp_s = "DDDDFDDDDF";
    foreach (grants[i]) grants[i] = 0;
    ng = 0;
    prev = 1'b0;
    drive(1, 32'h100, 1, 0, 32'h800, 0, 0, 0, 1, 32'h77);
    for (int c = 0; c < 300 && ng < 10; c++) begin
      @(negedge clock);
      bus.fetch_enable = !bus.data_valid;
      if ((bus.mem_read || bus.mem_write) && !prev) begin
        grants[ng] = bus.mem_address == 32'h100 ? 8'h46 : 8'h44;
        ng++;
      end
      prev = bus.mem_read || bus.mem_write;
    end
    for (int i = 0; i < 10; i++) check($sformatf("starve%0d", i), 160'(grants[i]), 160'(exp_s[i]));
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (4) @(negedge clock);
    bus.mem_read_valid = 1'b0;
    // fetch abandoned while waiting for its response
    @(negedge clock);
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 20 && !bus.mem_read; c++) @(negedge clock);
    #1 check("abn_cmd", 160'({bus.mem_read, bus.mem_address}), 160'({1'b1, 32'h100}));
    @(negedge clock);
    bus.fetch_address = 32'h300;
    @(negedge clock);
    bus.mem_read_valid = 1'b1;
    bus.mem_read_data = 32'h11;
    @(negedge clock);
    bus.mem_read_valid = 1'b0;
    #1 check("abn_drop", 160'(bus.fetch_valid), 160'd0);
    @(negedge clock);
    #1 check("abn_regrant", 160'({bus.mem_read, bus.mem_address, bus.fetch_valid}), 160'({1'b1, 32'h300, 1'b0}));
    @(negedge clock);
    bus.mem_read_valid = 1'b1;
    bus.mem_read_data = 32'h22;
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("abn_hit", 160'({bus.fetch_valid, bus.fetch_data}), 160'({1'b1, 32'h22}));
    // reset asserted while a load waits for its response
    @(negedge clock);
    drive(0, 0, 1, 0, 32'h500, 0, 0, 0, 0, 0);
    @(negedge clock);
    @(negedge clock);
    #1 check("rst_cmd_seen", 160'({bus.mem_read, bus.mem_address}), 160'({1'b0, 32'h500}));
    #1 reset_n = 1'b0;
    #1 check("rst_async", dut_tup(0), 160'd0);
    @(negedge clock);
    #1 check("rst_hold", dut_tup(0), 160'd0);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55);
    @(negedge clock);
    bus.mem_read_valid = 1'b0;
    #1 check("rst_late1", 160'({bus.data_valid, bus.mem_read, bus.mem_write}), 160'd0);
    @(negedge clock);
    #1 check("rst_late2", 160'({bus.data_valid, bus.mem_read, bus.mem_write, bus.data_read_data}), 160'd0);
    // randomized run from the freshly reset state
    owner = 0;
    wr = 1'b0;
    acc = 1'b0;
    cnt = 0;
    e_fv = 1'b0;
    e_dv = 1'b0;
    m_addr = 32'd0;
    m_wd = 32'd0;
    m_be = 4'd0;
    e_fd = 32'd0;
    e_dd = 32'd0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clock);
      k = $urandom_range(0, 3);
      fa_r = $urandom_range(0, 1) != 0 ? 32'h104 : 32'h100;
      da_r = $urandom;
      drive($urandom_range(0, 3) != 0, fa_r, k == 1, k == 2, da_r, $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom);
      #1 check($sformatf("rand%0d", n), dut_tup(0),
               tup(owner != 0 && !acc && !wr, owner != 0 && wr, m_addr, m_wd, m_be, e_fv, e_fd, e_dv, e_dd,
                   (bus.data_read || bus.data_write) && !e_dv, 0));
      @(posedge clock);
      model_step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
